// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle base ALU plus iterative RV-M multiply/divide unit with valid/ready handshake
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      op_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] out
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     cnt;
    logic [XLEN-1:0]   hi, lo, md;
    logic [2:0]        fn;
    logic              neg;
    logic              accept, sa, sb, dz, neg_n;
    logic [XLEN-1:0]   alu_res, mag_a, mag_b, nhi, nlo, q_or_r, m_res;
    logic [XLEN:0]     sum, rsh, diff;
    logic [2*XLEN-1:0] sprod;

    assign ready_o = (state == IDLE) || (state == DONE && ready_i);
    assign accept  = valid_i && ready_o && !kill_i;

    // base ALU result from the live request operands
    always_comb begin
        alu_res = '0;
        case (op_i[3:0])
            4'b0000: alu_res = a_i + b_i;
            4'b1000: alu_res = a_i - b_i;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            4'b0111: alu_res = a_i & b_i;
            4'b0110: alu_res = a_i | b_i;
            4'b0100: alu_res = a_i ^ b_i;
            4'b0001: alu_res = a_i << b_i[SW-1:0];
            4'b0101: alu_res = a_i >> b_i[SW-1:0];
            4'b1101: alu_res = $signed(a_i) >>> b_i[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    // M-op entry: operand magnitudes and the sign to reapply at the end
    always_comb begin
        sa    = a_i[XLEN-1] & (op_i[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
        sb    = b_i[XLEN-1] & (op_i[2:0] inside {3'b001, 3'b100, 3'b110});
        dz    = b_i == '0;
        mag_a = sa ? -a_i : a_i;
        mag_b = sb ? -b_i : b_i;
        neg_n = op_i[2] ? (op_i[1] ? sa : (sa ^ sb) & ~dz) : sa ^ sb;
    end

    // one shift-add or restoring-divide step, plus the signed result it would finish with
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        rsh    = {hi, lo[XLEN-1]};
        diff   = rsh - {1'b0, md};
        nhi    = fn[2] ? (diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
        nlo    = fn[2] ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
        q_or_r = fn[1] ? nhi : nlo;
        sprod  = neg ? -{nhi, nlo} : {nhi, nlo};
        m_res  = fn[2] ? (neg ? -q_or_r : q_or_r)
                       : (fn[1:0] == 2'b00 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN]);
    end

    // control FSM with datapath registers; kill beats acceptance and ready_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            out     <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            md      <= '0;
            fn      <= '0;
            neg     <= 1'b0;
        end else if (kill_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            cnt <= '0;
            if (op_i[4]) begin
                state   <= BUSY;
                valid_o <= 1'b0;
                fn      <= op_i[2:0];
                neg     <= neg_n;
                hi      <= '0;
                lo      <= op_i[2] ? mag_a : mag_b;
                md      <= op_i[2] ? mag_b : mag_a;
            end else begin
                state   <= DONE;
                valid_o <= 1'b1;
                out     <= alu_res;
            end
        end else if (state == BUSY) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == SW'(XLEN - 1)) begin
                state   <= DONE;
                valid_o <= 1'b1;
                out     <= m_res;
            end
        end else if (state == DONE && ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed scoreboard bench for alu_mdu at XLEN=32 and XLEN=8
module tb_alu_mdu;
    localparam logic [4:0] ADD = 5'h00, SUB = 5'h08, SLT = 5'h02, SLTU = 5'h03;
    localparam logic [4:0] AND_ = 5'h07, OR_ = 5'h06, XOR_ = 5'h04, SLL = 5'h01;
    localparam logic [4:0] SRL = 5'h05, SRA = 5'h0D, BAD = 5'h0F;
    localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
    localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1, ready_o, valid_o;
    logic [31:0] a_i = '0, b_i = '0, out;
    logic [4:0]  op_i = '0;
    logic        v8 = 1'b0, k8 = 1'b0, r8 = 1'b1, rdy8, vo8;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic [4:0]  op8 = '0;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i),
        .op_i(op_i), .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i), .out(out)
    );

    alu_mdu #(.XLEN(8)) u8 (
        .clk(clk), .rst(rst), .valid_i(v8), .ready_o(rdy8), .a_i(a8), .b_i(b8),
        .op_i(op8), .kill_i(k8), .valid_o(vo8), .ready_i(r8), .out(out8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pop_exp(output logic [31:0] e);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int n = 0;
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        while (!ready_o && n < 100) begin @(posedge clk); #1; n++; end
        chk("send ready", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic collect(input string tag, input int lat_exp);
        int lat = 1;
        logic [31:0] e;
        while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
        chk({tag, " valid"}, 32'(valid_o), 32'd1);
        chk({tag, " lat"}, 32'(lat), 32'(lat_exp));
        pop_exp(e);
        chk(tag, out, e);
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat);
        send(op, a, b, e);
        collect(tag, lat);
    endtask

    task automatic run8(input string tag, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e, input int lat_exp);
        int lat = 1;
        logic [31:0] ev;
        op8 = op; a8 = a; b8 = b; v8 = 1'b1;
        chk({tag, " ready"}, 32'(rdy8), 32'd1);
        @(posedge clk); #1;
        v8 = 1'b0;
        exp_q.push_back(32'(e));
        while (!vo8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk({tag, " valid"}, 32'(vo8), 32'd1);
        chk({tag, " lat"}, 32'(lat), 32'(lat_exp));
        pop_exp(ev);
        chk(tag, 32'(out8), ev);
    endtask

    initial begin
        logic [31:0] e;
        #12;
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst out", out, 32'd0);
        chk("rst ready_o", 32'(ready_o), 32'd1);
        chk("rst8 valid_o", 32'(vo8), 32'd0);
        chk("rst8 ready_o", 32'(rdy8), 32'd1);
        rst = 1'b0;
        run("sub", SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run("sra", SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
        run("add wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run("sll", SLL, 32'd1, 32'h23, 32'd8, 1);
        run("srl", SRL, 32'h8000_0000, 32'h1F, 32'd1, 1);
        run("and", AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        run("or", OR_, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1);
        run("xor", XOR_, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0, 1);
        run("undef", BAD, 32'h1234_5678, 32'h1, 32'd0, 1);
        // back-to-back: one result per cycle
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_i = ADD; a_i = 32'(i * 100); b_i = 32'd7; valid_i = 1'b1;
            exp_q.push_back(32'(i * 100 + 7));
            @(posedge clk); #1;
            chk("b2b valid", 32'(valid_o), 32'd1);
            pop_exp(e);
            chk("b2b out", out, e);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk("b2b drain", 32'(valid_o), 32'd0);
        // backpressure hold, with a competing request that must not be taken
        ready_i = 1'b0;
        send(ADD, 32'h11, 32'h22, 32'h33);
        op_i = SUB; a_i = 32'd9; b_i = 32'd1; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold valid", 32'(valid_o), 32'd1);
            chk("hold out", out, 32'h33);
            chk("hold ready_o", 32'(ready_o), 32'd0);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        collect("hold", 1);
        @(posedge clk); #1;
        chk("hold drain", 32'(valid_o), 32'd0);
        // M ops
        send(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        chk("busy ready_o", 32'(ready_o), 32'd0);
        collect("mulh", 33);
        run("mul", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
        run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("mulh neg", MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33);
        run("mul big", MUL, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 33);
        run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run("divu dz", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
        run("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("div dz", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
        run("rem dz", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
        run("remu dz", REMU, 32'd7, 32'd0, 32'd7, 33);
        run("divu", DIVU, 32'd1000, 32'd7, 32'd142, 33);
        run("remu", REMU, 32'd1000, 32'd7, 32'd6, 33);
        // kill in BUSY cycle 10
        send(MULH, 32'd3, 32'd4, 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        exp_q.delete();
        chk("kill valid_o", 32'(valid_o), 32'd0);
        chk("kill ready_o", 32'(ready_o), 32'd1);
        repeat (40) begin @(posedge clk); #1; end
        chk("kill stale", 32'(valid_o), 32'd0);
        run("post kill add", ADD, 32'd1, 32'd2, 32'd3, 1);
        @(posedge clk); #1;
        // reset pulse while in DONE
        ready_i = 1'b0;
        send(ADD, 32'd5, 32'd6, 32'd11);
        chk("pre rst valid", 32'(valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst done valid_o", 32'(valid_o), 32'd0);
        chk("rst done out", out, 32'd0);
        chk("rst done ready_o", 32'(ready_o), 32'd1);
        #2 rst = 1'b0;
        exp_q.delete();
        ready_i = 1'b1;
        run("post rst add", ADD, 32'd1, 32'd2, 32'd3, 1);
        @(posedge clk); #1;
        // XLEN=8 instance
        run8("divu8", DIVU, 8'd200, 8'd7, 8'd28, 9);
        @(posedge clk); #1;
        run8("div8 ovf", DIV, 8'h80, 8'hFF, 8'h80, 9);
        @(posedge clk); #1;
        op8 = DIVU; a8 = 8'd200; b8 = 8'd7; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        k8 = 1'b1;
        @(posedge clk); #1;
        k8 = 1'b0;
        chk("kill8 valid_o", 32'(vo8), 32'd0);
        chk("kill8 ready_o", 32'(rdy8), 32'd1);
        run8("post kill8 add", ADD, 8'd1, 8'd2, 8'd3, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
